// File: rtl/cdc_pkg.sv
// ============================================================================
//  Module   : cdc_pkg
//  Purpose  : Shared types and constants for the req/ack pulse synchronizer
//             handshake (receiver side and reusable synchronizer).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cdc_pkg;

    // Handshake state of the destination-side responder
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELIVER = 2'd1,
        ACK     = 2'd2
    } hs_state_t;

    // Default depth of a level synchronizer chain
    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage : cdc_pkg

`default_nettype wire

// File: rtl/sync_ff.sv
// ============================================================================
//  Module   : sync_ff
//  Purpose  : N-stage level synchronizer for a single asynchronous bit.
//             Used for req on the receive side and for ack on the source side.
//             STAGES must be 2..4.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_ff
    import cdc_pkg::*;
#(
    parameter int STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] r_chain;

    // Shift the asynchronous level through the flop chain; bit 0 is the
    // metastability-catching stage, the MSB is the clean synchronized level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[STAGES-1];

endmodule : sync_ff

`default_nettype wire

// File: rtl/hs_pulse_receiver.sv
// ============================================================================
//  Module   : hs_pulse_receiver
//  Purpose  : Destination-side responder of a 4-phase req/ack pulse
//             synchronizer. Converts each req assertion into exactly one
//             valid/ready event, returns a registered ack level, counts
//             accepted events and flags source protocol violations.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hs_pulse_receiver
    import cdc_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_in,
    output logic             ack_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_pulse,
    output logic             busy,
    output logic [CNT_W-1:0] evt_count,
    output logic             proto_err
);

    hs_state_t        r_state;
    logic             r_ack;
    logic             r_valid;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    logic             w_req_sync;
    logic             w_accept;

    // Bring the source-domain req level into this clock domain
    sync_ff #(
        .STAGES  (SYNC_STAGES)
    ) u_req_sync (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_async (req_in),
        .o_sync  (w_req_sync)
    );

    // An event is consumed only while req is still asserted; a withdrawn req
    // takes priority and aborts the event instead.
    assign w_accept = r_valid & out_ready & w_req_sync;

    // Handshake FSM; ack and valid are registered alongside the state so the
    // ack level leaving this domain comes straight from a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_sync) begin
                        r_state <= DELIVER;
                        r_valid <= 1'b1;
                    end
                end
                DELIVER: begin
                    if (!w_req_sync) begin
                        // Source dropped req before being acknowledged
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_err   <= 1'b1;
                    end else if (out_ready) begin
                        r_state <= ACK;
                        r_valid <= 1'b0;
                        r_ack   <= 1'b1;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                ACK: begin
                    // Hold ack until req is seen low; a long req gives no
                    // second event.
                    if (!w_req_sync) begin
                        r_state <= IDLE;
                        r_ack   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    assign ack_out   = r_ack;
    assign out_valid = r_valid;
    assign out_pulse = w_accept;
    assign busy      = (r_state != IDLE);
    assign evt_count = r_cnt;
    assign proto_err = r_err;

endmodule : hs_pulse_receiver

`default_nettype wire

// File: tb/tb_hs_pulse_receiver.sv
// ============================================================================
//  Module   : tb_hs_pulse_receiver
//  Purpose  : Self-checking bench for hs_pulse_receiver: directed handshakes
//             with literal expectations plus an event-level reference model
//             compared on every falling clock edge.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hs_pulse_receiver;

    localparam int S = 2;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic       req_in    = 1'b0;
    logic       out_ready = 1'b0;

    logic       ack_out, out_valid, out_pulse, busy, proto_err;
    logic [7:0] evt_count;
    logic       ack2, valid2, pulse2, busy2, err2;
    logic [1:0] cnt2;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;

    always #5 clk = ~clk;

    hs_pulse_receiver #(.SYNC_STAGES(S), .CNT_W(8)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_in    (req_in),
        .ack_out   (ack_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pulse (out_pulse),
        .busy      (busy),
        .evt_count (evt_count),
        .proto_err (proto_err)
    );

    // Narrow counter instance, same stimulus, for the wrap behaviour
    hs_pulse_receiver #(.SYNC_STAGES(S), .CNT_W(2)) u_dut_w2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_in    (req_in),
        .ack_out   (ack2),
        .out_valid (valid2),
        .out_ready (out_ready),
        .out_pulse (pulse2),
        .busy      (busy2),
        .evt_count (cnt2),
        .proto_err (err2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // req history: the synchronized req is the req_in value sampled S edges ago
    logic [S-1:0] m_hist;
    logic         m_rs;
    bit           m_pend, m_ack, m_err;
    int           m_cnt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_hist = '0;
            m_pend = 0;
            m_ack  = 0;
            m_err  = 0;
            m_cnt  = 0;
        end else begin
            m_rs = m_hist[S-1];
            if (m_pend) begin
                if (!m_rs) begin
                    m_err  = 1;
                    m_pend = 0;
                end else if (out_ready) begin
                    m_pend = 0;
                    m_ack  = 1;
                    m_cnt  = m_cnt + 1;
                end
            end else if (m_ack) begin
                if (!m_rs) m_ack = 0;
            end else if (m_rs) begin
                m_pend = 1;
            end
            m_hist = {m_hist[S-2:0], req_in};
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("m_valid", out_valid, m_pend);
        chk("m_ack",   ack_out,   m_ack);
        chk("m_busy",  busy,      m_pend | m_ack);
        chk("m_pulse", out_pulse, m_pend & out_ready & m_hist[S-1]);
        chk("m_cnt",   evt_count, m_cnt % 256);
        chk("m_err",   proto_err, m_err);
        chk("m_cnt2",  cnt2,      m_cnt % 4);
        chk("m_ack2",  ack2,      m_ack);
        if (out_pulse === 1'b1) n_pulses++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic sigsel(input int which);
        return (which == 0) ? ack_out : out_valid;
    endfunction

    task automatic wait_for(input int which, input logic val, input string name);
        int k = 0;
        while (sigsel(which) !== val && k < 40) begin
            tick();
            k++;
        end
        chk(name, sigsel(which), val);
    endtask

    task automatic handshake();
        req_in = 1'b1;
        wait_for(0, 1'b1, "hs_ack_rise");
        req_in = 1'b0;
        wait_for(0, 1'b0, "hs_ack_fall");
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int p0;
        logic [1:0] exp2 [4];
        exp2[0] = 2'd2; exp2[1] = 2'd3; exp2[2] = 2'd0; exp2[3] = 2'd1;

        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ack",   ack_out,   0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy",  busy,      0);
        chk("rst_err",   proto_err, 0);
        chk("rst_cnt",   evt_count, 0);
        reset_n = 1'b1;
        tick();
        tick();

        // Basic latency: req stable before edge 1
        req_in = 1'b1;
        tick();
        tick();
        chk("lat_valid_e2", out_valid, 0);
        tick();
        chk("lat_valid_e3", out_valid, 1);
        chk("lat_pulse_e3", out_pulse, 1);
        chk("lat_ack_e3",   ack_out,   0);
        tick();
        chk("lat_valid_e4", out_valid, 0);
        chk("lat_pulse_e4", out_pulse, 0);
        chk("lat_ack_e4",   ack_out,   1);
        chk("lat_cnt",      evt_count, 1);
        req_in = 1'b0;
        tick();
        chk("fall_ack_1", ack_out, 1);
        tick();
        chk("fall_ack_2", ack_out, 1);
        tick();
        chk("fall_ack_3", ack_out, 0);
        chk("fall_busy",  busy,    0);
        chk("basic_err",  proto_err, 0);

        // Backpressure: five stalled cycles then acceptance
        out_ready = 1'b0;
        p0 = n_pulses;
        req_in = 1'b1;
        wait_for(1, 1'b1, "bp_valid_rise");
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_held", out_valid, 1);
            chk("bp_ack_low",    ack_out,   0);
            chk("bp_busy",       busy,      1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_valid_6", out_valid, 1);
        chk("bp_pulse",   out_pulse, 1);
        chk("bp_ack_acc", ack_out,   0);
        tick();
        chk("bp_ack_after", ack_out, 1);
        chk("bp_busy_ack",  busy,    1);
        chk("bp_npulse",    n_pulses - p0, 1);
        req_in = 1'b0;
        wait_for(0, 1'b0, "bp_ack_fall");
        tick();
        chk("bp_cnt", evt_count, 2);

        // Source withdraws req while the event is stalled
        out_ready = 1'b0;
        p0 = n_pulses;
        req_in = 1'b1;
        wait_for(1, 1'b1, "pe_valid_rise");
        req_in = 1'b0;
        repeat (4) tick();
        chk("pe_err",    proto_err, 1);
        chk("pe_valid",  out_valid, 0);
        chk("pe_busy",   busy,      0);
        chk("pe_cnt",    evt_count, 2);
        chk("pe_npulse", n_pulses - p0, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            handshake();
            chk("pe_err_sticky", proto_err, 1);
        end
        chk("pe_cnt_after", evt_count, 5);

        // Long req: one event only, ack held until req_sync falls
        p0 = n_pulses;
        req_in = 1'b1;
        wait_for(0, 1'b1, "long_ack_rise");
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("long_ack_held", ack_out, 1);
        end
        req_in = 1'b0;
        tick();
        chk("long_ack_f1", ack_out, 1);
        tick();
        chk("long_ack_f2", ack_out, 1);
        tick();
        chk("long_ack_f3", ack_out, 0);
        chk("long_npulse", n_pulses - p0, 1);
        chk("long_cnt",    evt_count, 6);

        // Asynchronous reset in the middle of ACK
        req_in = 1'b1;
        wait_for(0, 1'b1, "rm_ack_rise");
        reset_n = 1'b0;
        #1;
        chk("rm_ack",   ack_out,   0);
        chk("rm_busy",  busy,      0);
        chk("rm_valid", out_valid, 0);
        chk("rm_cnt",   evt_count, 0);
        chk("rm_cnt2",  cnt2,      0);
        chk("rm_err",   proto_err, 0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        tick();
        tick();
        chk("rr_valid_e2", out_valid, 0);
        tick();
        chk("rr_valid_e3", out_valid, 1);
        chk("rr_pulse_e3", out_pulse, 1);
        tick();
        chk("rr_ack",  ack_out, 1);
        chk("rr_cnt",  evt_count, 1);
        chk("wrap_c1", cnt2, 1);
        req_in = 1'b0;
        wait_for(0, 1'b0, "rr_ack_fall");
        tick();

        // Counter wrap on the 2-bit instance: 1,2,3,0,1
        for (int i = 0; i < 4; i++) begin
            handshake();
            chk("wrap_seq", cnt2, exp2[i]);
        end
        chk("wrap_cnt8", evt_count, 5);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hs_pulse_receiver

`default_nettype wire
